// File: rtl/itch_pkg.sv
// Shared constants and types for the ITCH decoder-to-order-book message path.
package itch_pkg;

    localparam int unsigned NUM_SRC = 6;

    localparam int unsigned SRC_ADD     = 0;
    localparam int unsigned SRC_CANCEL  = 1;
    localparam int unsigned SRC_DELETE  = 2;
    localparam int unsigned SRC_REPLACE = 3;
    localparam int unsigned SRC_EXEC    = 4;
    localparam int unsigned SRC_TRADE   = 5;

    localparam logic [7:0] TYPE_ADD     = 8'h41; // 'A'
    localparam logic [7:0] TYPE_CANCEL  = 8'h58; // 'X'
    localparam logic [7:0] TYPE_DELETE  = 8'h44; // 'D'
    localparam logic [7:0] TYPE_REPLACE = 8'h55; // 'U'
    localparam logic [7:0] TYPE_EXEC    = 8'h45; // 'E'
    localparam logic [7:0] TYPE_TRADE   = 8'h50; // 'P'

    typedef logic [2:0] src_idx_t;

    // Index following g, wrapping modulo n.
    function automatic src_idx_t wrap_inc(input src_idx_t g, input int unsigned n);
        return (32'(g) + 32'd1 >= n) ? src_idx_t'(0) : g + 3'd1;
    endfunction

endpackage

// File: rtl/itch_msg_arbiter_if.sv
// Decoder completion inputs and the merged valid/ready message output.
interface itch_msg_arbiter_if #(
    parameter int unsigned NUM_SRC = 6,
    parameter int unsigned SEQ_W   = 16
);
    import itch_pkg::*;

    logic [NUM_SRC-1:0]      src_valid;
    logic [NUM_SRC-1:0][7:0] src_type;
    logic                    out_valid;
    logic                    out_ready;
    src_idx_t                out_src;
    logic [7:0]              out_type;
    logic [SEQ_W-1:0]        out_seq;

    modport master (
        output src_valid, src_type, out_ready,
        input  out_valid, out_src, out_type, out_seq
    );

    modport slave (
        input  src_valid, src_type, out_ready,
        output out_valid, out_src, out_type, out_seq
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin picker; the search starts at ptr_i and wraps.
module rr_arbiter
    import itch_pkg::*;
#(
    parameter int unsigned N = 6
) (
    input  logic [N-1:0] req_i,
    input  src_idx_t     ptr_i,
    output logic         grant_valid_o,
    output src_idx_t     grant_idx_o
);

    always_comb begin
        int unsigned idx;
        src_idx_t    sel;
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        sel           = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = src_idx_t'(idx);
            if (!grant_valid_o && req_i[sel]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = sel;
            end
        end
    end

endmodule

// File: rtl/itch_msg_arbiter.sv
// Merges per-type ITCH decoder pulses through one-deep slots into a sequenced
// valid/ready stream; collisions on an occupied slot are dropped and counted.
module itch_msg_arbiter #(
    parameter int unsigned NUM_SRC = itch_pkg::NUM_SRC,
    parameter int unsigned SEQ_W   = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    itch_msg_arbiter_if.slave  bus,
    input  logic               clr_stats,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [NUM_SRC-1:0] ovf_flags
);
    import itch_pkg::*;

    logic [NUM_SRC-1:0]      pend_v_q;
    logic [NUM_SRC-1:0][7:0] pend_type_q;
    logic                    out_valid_q;
    src_idx_t                out_src_q;
    logic [7:0]              out_type_q;
    logic [SEQ_W-1:0]        out_seq_q;
    logic [SEQ_W-1:0]        seq_ctr_q;
    src_idx_t                rr_ptr_q;
    logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;
    logic [NUM_SRC-1:0]      ovf_q;

    logic               load, grant_valid, grant;
    src_idx_t           grant_idx;
    logic [NUM_SRC-1:0] grant_oh, accept, drop;
    logic [CNT_W:0]     drop_sum;

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_rr (
        .req_i         (pend_v_q),
        .ptr_i         (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_comb begin
        load     = !out_valid_q || bus.out_ready;
        grant    = load && grant_valid;
        grant_oh = '0;
        if (grant) begin
            grant_oh[grant_idx] = 1'b1;
        end
        // A slot being drained this cycle can take a new arrival.
        accept     = bus.src_valid & (~pend_v_q | grant_oh);
        drop       = bus.src_valid & ~accept;
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'($countones(drop));
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_q    <= '0;
            pend_type_q <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            out_type_q  <= '0;
            out_seq_q   <= '0;
            seq_ctr_q   <= '0;
            rr_ptr_q    <= '0;
            drop_cnt_q  <= '0;
            ovf_q       <= '0;
        end else begin
            pend_v_q <= (pend_v_q & ~grant_oh) | accept;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept[i]) begin
                    pend_type_q[i] <= bus.src_type[i];
                end
            end
            if (load) begin
                out_valid_q <= grant_valid;
            end
            if (grant) begin
                out_src_q  <= grant_idx;
                out_type_q <= pend_type_q[grant_idx];
                out_seq_q  <= seq_ctr_q;
                seq_ctr_q  <= seq_ctr_q + SEQ_W'(1);
                rr_ptr_q   <= wrap_inc(grant_idx, NUM_SRC);
            end
            if (clr_stats) begin
                drop_cnt_q <= '0;
                ovf_q      <= '0;
            end else begin
                drop_cnt_q <= drop_cnt_d;
                ovf_q      <= ovf_q | drop;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_type  = out_type_q;
    assign bus.out_seq   = out_seq_q;
    assign drop_cnt      = drop_cnt_q;
    assign ovf_flags     = ovf_q;

endmodule

// File: tb/tb_itch_msg_arbiter.sv
// Bench for itch_msg_arbiter: directed vector table, corner sequences and a
// randomized run against a slot/queue-level reference model.
module tb_itch_msg_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_stats = 1'b0;
    logic [15:0] drop_cnt;
    logic [5:0]  ovf_flags;

    itch_msg_arbiter_if #(.NUM_SRC(6), .SEQ_W(16)) bus ();

    itch_msg_arbiter #(
        .NUM_SRC (6),
        .SEQ_W   (16),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_stats (clr_stats),
        .drop_cnt  (drop_cnt),
        .ovf_flags (ovf_flags)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    string phase = "init";

    // Reference model state: slots, output register, counters as plain integers.
    bit         m_pend[6];
    logic [7:0] m_ptype[6];
    bit         m_ovf[6];
    bit         m_ov;
    int         m_src, m_seq, m_ctr, m_rr, m_drops;
    logic [7:0] m_type;

    logic [7:0] type_tab[6] = '{8'h41, 8'h58, 8'h44, 8'h55, 8'h45, 8'h50};

    typedef struct {
        bit         do_rst;
        logic [5:0] sv;
        bit         rdy;
        bit         clr;
        bit         ov;
        logic [2:0] src;
        logic [7:0] ty;
        logic [15:0] seq;
        logic [15:0] dc;
        logic [5:0] ovf;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s/%s actual=%0h required=%0h at %0t", phase, name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_pend[i] = 0; m_ptype[i] = 8'h0; m_ovf[i] = 0;
        end
        m_ov = 0; m_src = 0; m_seq = 0; m_ctr = 0; m_rr = 0; m_drops = 0; m_type = 8'h0;
    endtask

    task automatic model_step(input logic [5:0] sv, input bit rdy, input bit clr);
        bit load;
        int g, nd, idx;
        load = !m_ov || rdy;
        g = -1;
        nd = 0;
        if (load) begin
            for (int k = 0; k < 6; k++) begin
                idx = (m_rr + k) % 6;
                if (g < 0 && m_pend[idx]) g = idx;
            end
            m_ov = (g >= 0);
            if (g >= 0) begin
                m_src = g; m_type = m_ptype[g]; m_seq = m_ctr;
                m_ctr = (m_ctr + 1) % 65536;
                m_rr = (g + 1) % 6;
                m_pend[g] = 0;
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (sv[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1; m_ptype[i] = bus.src_type[i];
                end else begin
                    nd++; m_ovf[i] = 1;
                end
            end
        end
        if (clr) begin
            m_drops = 0;
            for (int i = 0; i < 6; i++) m_ovf[i] = 0;
        end else begin
            m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
        end
    endtask

    task automatic compare_model();
        logic [5:0] e;
        for (int i = 0; i < 6; i++) e[i] = m_ovf[i];
        check("valid", 32'(bus.out_valid), 32'(m_ov));
        if (m_ov) begin
            check("src", 32'(bus.out_src), 32'(m_src));
            check("type", 32'(bus.out_type), 32'(m_type));
            check("seq", 32'(bus.out_seq), 32'(m_seq));
        end
        check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        check("ovf", 32'(ovf_flags), 32'(e));
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input logic [5:0] sv, input bit rdy, input bit clr, input bit chk);
        bus.src_valid = sv;
        bus.out_ready = rdy;
        clr_stats = clr;
        model_step(sv, rdy, clr);
        @(posedge clk);
        #1;
        bus.src_valid = '0;
        clr_stats = 1'b0;
        if (chk) compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.src_valid = '0;
        bus.out_ready = 1'b0;
        clr_stats = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void add(input bit r, input logic [5:0] sv, input bit rdy, input bit clr,
                                input bit ov, input int src, input int seq, input int dc,
                                input logic [5:0] ovf);
        vec_t v;
        v.do_rst = r; v.sv = sv; v.rdy = rdy; v.clr = clr; v.ov = ov;
        v.src = 3'(src); v.ty = type_tab[src % 6]; v.seq = 16'(seq); v.dc = 16'(dc);
        v.ovf = ovf;
        tv.push_back(v);
    endfunction

    initial begin
        logic [15:0] prev_seq;
        bit          saw_wrap;
        logic [5:0]  sv;

        bus.src_valid = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) bus.src_type[i] = type_tab[i];
        model_reset();

        // Single add
        add(1, 6'h01, 1, 0, 0, 0, 0, 0, 6'h00);
        add(0, 6'h00, 1, 0, 1, 0, 0, 0, 6'h00);
        add(0, 6'h00, 1, 0, 0, 0, 0, 0, 6'h00);
        // All six at once
        add(1, 6'h3F, 1, 0, 0, 0, 0, 0, 6'h00);
        for (int s = 0; s < 6; s++) add(0, 6'h00, 1, 0, 1, s, s, 0, 6'h00);
        add(0, 6'h00, 1, 0, 0, 0, 0, 0, 6'h00);
        // Back-pressure: add held, cancel pending, second cancel dropped
        add(1, 6'h01, 0, 0, 0, 0, 0, 0, 6'h00);
        add(0, 6'h02, 0, 0, 1, 0, 0, 0, 6'h00);
        add(0, 6'h00, 0, 0, 1, 0, 0, 0, 6'h00);
        add(0, 6'h02, 0, 0, 1, 0, 0, 1, 6'h02);
        add(0, 6'h00, 0, 0, 1, 0, 0, 1, 6'h02);
        add(0, 6'h00, 1, 0, 1, 1, 1, 1, 6'h02);
        add(0, 6'h00, 1, 0, 0, 0, 0, 1, 6'h02);
        // Fairness between sources 0 and 5
        add(1, 6'h21, 1, 0, 0, 0, 0, 0, 6'h00);
        add(0, 6'h21, 1, 0, 1, 0, 0, 1, 6'h20);
        add(0, 6'h21, 1, 0, 1, 5, 1, 2, 6'h21);
        add(0, 6'h21, 1, 0, 1, 0, 2, 3, 6'h21);
        add(0, 6'h00, 1, 0, 1, 5, 3, 3, 6'h21);
        add(0, 6'h00, 1, 0, 1, 0, 4, 3, 6'h21);
        add(0, 6'h00, 1, 0, 0, 0, 0, 3, 6'h21);
        // clr_stats coincident with a drop
        add(0, 6'h01, 0, 0, 0, 0, 0, 3, 6'h21);
        add(0, 6'h00, 0, 0, 1, 0, 5, 3, 6'h21);
        add(0, 6'h01, 0, 0, 1, 0, 5, 3, 6'h21);
        add(0, 6'h01, 0, 1, 1, 0, 5, 0, 6'h00);
        add(0, 6'h00, 1, 0, 1, 0, 6, 0, 6'h00);
        add(0, 6'h00, 1, 0, 0, 0, 0, 0, 6'h00);

        phase = "table";
        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].do_rst) do_reset();
            cycle(tv[i].sv, tv[i].rdy, tv[i].clr, 1'b0);
            check($sformatf("row%0d.valid", i), 32'(bus.out_valid), 32'(tv[i].ov));
            if (tv[i].ov) begin
                check($sformatf("row%0d.src", i), 32'(bus.out_src), 32'(tv[i].src));
                check($sformatf("row%0d.type", i), 32'(bus.out_type), 32'(tv[i].ty));
                check($sformatf("row%0d.seq", i), 32'(bus.out_seq), 32'(tv[i].seq));
            end
            check($sformatf("row%0d.drop_cnt", i), 32'(drop_cnt), 32'(tv[i].dc));
            check($sformatf("row%0d.ovf", i), 32'(ovf_flags), 32'(tv[i].ovf));
        end

        phase = "random";
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 6; i++) bus.src_type[i] = 8'($urandom);
            sv = 6'($urandom & $urandom);
            cycle(sv, ($urandom % 4) != 0, ($urandom % 64) == 0, 1'b1);
        end
        for (int i = 0; i < 6; i++) bus.src_type[i] = type_tab[i];

        phase = "async_reset";
        do_reset();
        for (int n = 0; n < 3; n++) cycle(6'h3F, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("valid", 32'(bus.out_valid), 32'h0);
        check("src", 32'(bus.out_src), 32'h0);
        check("type", 32'(bus.out_type), 32'h0);
        check("seq", 32'(bus.out_seq), 32'h0);
        check("drop_cnt", 32'(drop_cnt), 32'h0);
        check("ovf", 32'(ovf_flags), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(6'h21, 1'b1, 1'b0, 1'b1);
        cycle(6'h00, 1'b1, 1'b0, 1'b0);
        check("first.src", 32'(bus.out_src), 32'h0);
        check("first.seq", 32'(bus.out_seq), 32'h0);
        cycle(6'h00, 1'b1, 1'b0, 1'b0);
        check("second.src", 32'(bus.out_src), 32'h5);
        check("second.seq", 32'(bus.out_seq), 32'h1);

        phase = "saturate";
        do_reset();
        for (int n = 0; n < 12000 && m_drops < 65530; n++) cycle(6'h3F, 1'b0, 1'b0, 1'b0);
        compare_model();
        cycle(6'h3F, 1'b0, 1'b0, 1'b1);
        check("sat", 32'(drop_cnt), 32'hFFFF);
        cycle(6'h3F, 1'b0, 1'b0, 1'b0);
        check("sat_hold", 32'(drop_cnt), 32'hFFFF);
        check("ovf_all", 32'(ovf_flags), 32'h3F);

        phase = "seq_wrap";
        do_reset();
        saw_wrap = 1'b0;
        prev_seq = 16'h0;
        for (int n = 0; n < 65545; n++) begin
            cycle(6'h3F, 1'b1, 1'b0, (n % 4096 == 0) || (m_ctr < 4) || (m_ctr > 65532));
            if (bus.out_valid && prev_seq == 16'hFFFF && bus.out_seq == 16'h0) saw_wrap = 1'b1;
            prev_seq = bus.out_seq;
        end
        check("wrap_seen", 32'(saw_wrap), 32'h1);
        check("throughput", 32'(bus.out_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/itch_msg_arbiter.md
# itch_msg_arbiter

Merges the six per-type ITCH decoder completion pulses (add, cancel, delete, replace, exec, trade) into one ordered, flow-controlled message stream for the downstream order-book engine. Each decoder gets a one-deep pending slot. A round-robin arbiter drains the slots into a registered valid/ready output, and each granted message is stamped with a wrapping sequence number. Messages that arrive while their slot is still occupied are dropped and counted, so back-pressure never stalls the byte-serial parsers.

## Interface
Parameters:
- NUM_SRC, 6, number of decoder sources; index order is add=0, cancel=1, delete=2, replace=3, exec=4, trade=5.
- SEQ_W, 16, sequence-number width.
- CNT_W, 16, drop-counter width.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_valid  in  NUM_SRC  per-source single-cycle completion pulse (the decoders' *_internal_valid).
- src_type  in  NUM_SRC×8  per-source parsed type byte; sampled only while that source's src_valid is high.
- out_valid  out  1  output message valid.
- out_ready  in  1  downstream accept.
- out_src  out  3  index of the source that produced out_type.
- out_type  out  8  message type byte.
- out_seq  out  SEQ_W  message sequence number.
- clr_stats  in  1  single-cycle clear for drop_cnt and ovf_flags.
- drop_cnt  out  CNT_W  saturating count of dropped messages.
- ovf_flags  out  NUM_SRC  sticky per-source overflow flags.

## Operation
- Pending slots: pend_v[i] and pend_type[i].
  - A src_valid[i] pulse loads the slot when the slot is empty, or when it is being granted in the same cycle.
  - Otherwise the new message is dropped and the old one is kept. The drop sets ovf_flags[i] and increments drop_cnt.
- Output register load condition: `!out_valid || out_ready`.
  - When the condition holds and at least one pend_v is set, the round-robin winner is copied to out_src/out_type.
  - out_seq takes the current seq_ctr, seq_ctr then increments, and the winner's pend_v is cleared.
- Round-robin rule:
  - Search starts at rr_ptr and wraps modulo NUM_SRC.
  - After a grant to index g, rr_ptr = (g+1) mod NUM_SRC.
  - rr_ptr is unchanged when there is no grant.
- Output hold: out_src, out_type and out_seq stay stable while out_valid is high and out_ready is low.
- Sequence wrap: seq_ctr wraps from 2^SEQ_W−1 to 0.
- Drop counting arithmetic:
  - drop_cnt adds the popcount of the drops in a cycle (0..NUM_SRC).
  - The sum saturates at 2^CNT_W−1 and never wraps.
- clr_stats has priority: drop_cnt and ovf_flags become 0 in that cycle, and drops occurring in the same cycle are not counted.
- There is no FSM beyond the output register. Its states are EMPTY (out_valid=0) and HOLD (out_valid=1):
  - EMPTY→HOLD when any slot is pending.
  - HOLD→HOLD on out_ready with another slot pending (zero-bubble reload).
  - HOLD→EMPTY on out_ready with no slot pending.

## Timing
- Latency: a src_valid pulse in cycle N gives out_valid in cycle N+1 at the earliest. This applies when the output register is empty or accepted in cycle N+1−1, and the source wins arbitration.
- Sustained throughput: one message per cycle while out_ready is held high.
- Same-cycle bypass: none. A pulse is never presented in the cycle it arrives.
- Reset (asynchronous assert, synchronous release) sets all of the following to 0: out_valid, out_src, out_type, out_seq, drop_cnt, ovf_flags, pend_v, seq_ctr, rr_ptr.
- Reset mid-transfer discards every pending and held message. Sequence numbering restarts at 0.
- Inputs src_valid and src_type are sampled on the rising edge only. src_type is ignored when src_valid=0.

## Structure
- The shared package itch_pkg holds:
  - NUM_SRC and the source index constants SRC_ADD..SRC_TRADE.
  - The ITCH type byte constants 'A', 'X', 'D', 'U', 'E', 'P'.
  - The out_src typedef (3-bit).
- Sub-module rr_arbiter: an N-way round-robin picker. Inputs are the request vector and rr_ptr. Outputs are grant_valid and the grant index. It is purely combinational.
- All pointer, slot, counter and output registers live in itch_msg_arbiter.

## Test plan
- Single add: src_valid[0]=1 with type 0x41, out_ready=1. Required: out_valid in the next cycle with out_src=0, out_type=0x41, out_seq=0. Then out_valid drops.
- All six sources pulse in one cycle, out_ready=1. Required: six consecutive beats with out_src 0,1,2,3,4,5 and out_seq 0..5, drop_cnt=0.
- Back-pressure: out_ready=0 for 10 cycles while source 1 pulses twice. Required: the second pulse is dropped, drop_cnt=1, ovf_flags=0b000010, and the first message is held stable. After release, exactly one cancel message appears.
- Round-robin fairness: sources 0 and 5 pulse every cycle with out_ready=1. Required: grants alternate 0,5,0,5 and the drops are counted.
- Saturation and wrap:
  - Preload drop_cnt near 0xFFFF via drops; a 6-source drop cycle must stop at 0xFFFF.
  - seq_ctr must go 0xFFFF→0x0000 across 65537 messages.
  - clr_stats coincident with a drop must leave drop_cnt=0.
- Async reset asserted while out_valid=1 and slots are pending. Required: all outputs are 0 immediately. The first post-reset message has out_seq=0 and rr_ptr starts at source 0.
